// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: registered round-robin grant held for the
// owner's whole cycle, zero-dead-cycle handoff, and a per-strobe watchdog
// that error-terminates strobes no slave answers.
module wb_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [1:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [1:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [1:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic [1:0]  gnt_o
);

  localparam int NUM_M = 2;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t state;
  logic   last;
  logic [7:0] cnt;

  // Masters gathered into packed arrays so the mux and return path index by owner
  logic [NUM_M-1:0][31:0] adr, wdat, rdat;
  logic [NUM_M-1:0][1:0]  sel;
  logic [NUM_M-1:0]       we, cyc, stb, ack, err, gnt;
  logic owner, busy, own_cyc, own_stb, tmo;

  assign adr  = {m1_adr_i, m0_adr_i};
  assign wdat = {m1_dat_i, m0_dat_i};
  assign sel  = {m1_sel_i, m0_sel_i};
  assign we   = {m1_we_i,  m0_we_i};
  assign cyc  = {m1_cyc_i, m0_cyc_i};
  assign stb  = {m1_stb_i, m0_stb_i};

  assign gnt     = (state == GNT0) ? 2'b01 : (state == GNT1) ? 2'b10 : 2'b00;
  assign gnt_o   = gnt;
  assign owner   = (state == GNT1);
  assign busy    = |gnt;
  assign own_cyc = busy & cyc[owner];
  assign own_stb = own_cyc & stb[owner];
  // Only a live strobe can time out; a stale count after stb drops must not fire
  assign tmo     = own_stb & (cnt == TO_LAST);

  // Shared-bus request mux driven from the registered grant
  always_comb begin
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    wbm_sel_o = '0;
    wbm_we_o  = 1'b0;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    if (busy) begin
      wbm_adr_o = adr[owner];
      wbm_dat_o = wdat[owner];
      wbm_sel_o = sel[owner];
      wbm_we_o  = we[owner];
      wbm_cyc_o = own_cyc;
      wbm_stb_o = own_stb & ~tmo;
    end
  end

  // Return path: only the owner sees data, ack or err; ack beats a same-cycle timeout
  for (genvar m = 0; m < NUM_M; m++) begin : g_ret
    assign ack[m]  = gnt[m] & wbm_ack_i;
    assign err[m]  = gnt[m] & tmo & ~wbm_ack_i;
    assign rdat[m] = gnt[m] ? wbm_dat_i : 32'h0;
  end

  assign m0_dat_o = rdat[0];
  assign m1_dat_o = rdat[1];
  assign m0_ack_o = ack[0];
  assign m1_ack_o = ack[1];
  assign m0_err_o = err[0];
  assign m1_err_o = err[1];

  // Grant FSM with round-robin tie break and the watchdog counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      if (!busy || !own_stb || wbm_ack_i || tmo) cnt <= '0;
      else                                       cnt <= cnt + 8'd1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (cyc[0] && cyc[1]) begin
            state <= last ? GNT0 : GNT1;
            last  <= ~last;
          end else if (cyc[0]) begin
            state <= GNT0;
            last  <= 1'b0;
          end else if (cyc[1]) begin
            state <= GNT1;
            last  <= 1'b1;
          end
        end
        GNT0: if (!cyc[0]) begin
          cnt <= '0;
          if (cyc[1]) begin
            state <= GNT1;
            last  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        GNT1: if (!cyc[1]) begin
          cnt <= '0;
          if (cyc[0]) begin
            state <= GNT0;
            last  <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter (TIMEOUT=8): cycle table plus watchdog sequences,
// expected outputs queued as each cycle is driven and checked mid-cycle.
module tb_wb_arbiter;

  localparam logic [31:0] A0 = 32'h0000_1000, A1 = 32'h0000_2000;
  localparam logic [31:0] D0 = 32'hA0A0_A0A0, D1 = 32'hB1B1_B1B1;
  localparam logic [1:0]  S0 = 2'b01,         S1 = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, m0_rd, m1_rd;
  logic [1:0]  m0_sel, m1_sel, gnt;
  logic        m0_we, m0_cyc, m0_stb, m0_ack, m0_err;
  logic        m1_we, m1_cyc, m1_stb, m1_ack, m1_err;
  logic [31:0] wadr, wdat, rdat;
  logic [1:0]  wsel;
  logic        wwe, wcyc, wstb, wack;

  wb_arbiter #(.TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(m0_rd), .m0_ack_o(m0_ack),
    .m0_err_o(m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(m1_rd), .m1_ack_o(m1_ack),
    .m1_err_o(m1_err),
    .wbm_adr_o(wadr), .wbm_dat_o(wdat), .wbm_sel_o(wsel), .wbm_we_o(wwe),
    .wbm_cyc_o(wcyc), .wbm_stb_o(wstb), .wbm_dat_i(rdat), .wbm_ack_i(wack),
    .gnt_o(gnt)
  );

  // One cycle of stimulus and the outputs expected during it
  typedef struct {
    logic [5:0]  in;   // {rst, c0, s0, c1, s1, ack}
    logic [31:0] rd;   // slave read data, 0 = use a per-cycle tag
    logic [1:0]  gnt;
    logic [5:0]  out;  // {wcyc, wstb, ack0, ack1, err0, err1}
  } vec_t;

  typedef struct {
    int          idx;
    logic [1:0]  gnt;
    logic [5:0]  out;
    logic [31:0] d0, d1, adr, wd;
    logic [1:0]  sel;
    logic        we;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   tests = 0, fails = 0, cyc_n = 0;

  function automatic vec_t v(input logic [5:0] in, input logic [31:0] rd,
                             input logic [1:0] g, input logic [5:0] out);
    vec_t r;
    r.in = in; r.rd = rd; r.gnt = g; r.out = out;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, check at the falling edge
  task automatic apply(input vec_t t);
    exp_t e;
    logic [31:0] rd;
    #1;
    rd = (t.rd != 0) ? t.rd : {16'hD00D, 16'(cyc_n)};
    {rst, m0_cyc, m0_stb, m1_cyc, m1_stb, wack} = t.in;
    rdat = rd;
    e.idx = cyc_n; e.gnt = t.gnt; e.out = t.out;
    e.d0  = t.gnt[0] ? rd : 32'h0;
    e.d1  = t.gnt[1] ? rd : 32'h0;
    e.adr = t.gnt[0] ? A0 : t.gnt[1] ? A1 : 32'h0;
    e.wd  = t.gnt[0] ? D0 : t.gnt[1] ? D1 : 32'h0;
    e.sel = t.gnt[0] ? S0 : t.gnt[1] ? S1 : 2'b00;
    e.we  = t.gnt[1];
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk("gnt",  e.idx, 32'(gnt), 32'(e.gnt));
    chk("ctl",  e.idx, 32'({wcyc, wstb, m0_ack, m1_ack, m0_err, m1_err}), 32'(e.out));
    chk("dat0", e.idx, m0_rd, e.d0);
    chk("dat1", e.idx, m1_rd, e.d1);
    chk("bus",  e.idx, {wadr[15:0], wdat[15:0]}, {e.adr[15:0], e.wd[15:0]});
    chk("selwe", e.idx, 32'({wsel, wwe}), 32'({e.sel, e.we}));
    cyc_n++;
    @(posedge clk);
  endtask

  // Lone strobe from master m with no slave; optionally ack lands on the timeout cycle
  task automatic run_timeout(input int m, input bit ack_late);
    logic [5:0] req, reqa;
    logic [1:0] g;
    req  = (m == 0) ? 6'b011000 : 6'b000110;
    reqa = req | 6'b000001;
    g    = (m == 0) ? 2'b01 : 2'b10;
    apply(v(req, 0, 2'b00, 6'b000000));
    for (int k = 0; k < 7; k++) apply(v(req, 0, g, 6'b110000));
    if (ack_late)
      apply(v(reqa, 32'hBEEF_0001, g, (m == 0) ? 6'b101000 : 6'b100100));
    else
      apply(v(req, 0, g, (m == 0) ? 6'b100010 : 6'b100001));
    apply(v(req, 0, g, 6'b110000));       // counter restarted, strobe live again
    apply(v(6'b000000, 0, g, 6'b000000));
    apply(v(6'b000000, 0, 2'b00, 6'b000000));
  endtask

  initial begin
    rst = 1'b1; wack = 1'b0; rdat = '0;
    m0_adr = A0; m0_dat = D0; m0_sel = S0; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    m1_adr = A1; m1_dat = D1; m1_sel = S1; m1_we = 1'b1; m1_cyc = 1'b0; m1_stb = 1'b0;
    repeat (2) @(posedge clk);

    // master 0 alone reads, slave acks on the third granted cycle
    tbl.push_back(v(6'b100000, 0,            2'b00, 6'b000000));
    tbl.push_back(v(6'b011000, 0,            2'b00, 6'b000000));
    tbl.push_back(v(6'b011000, 0,            2'b01, 6'b110000));
    tbl.push_back(v(6'b011000, 0,            2'b01, 6'b110000));
    tbl.push_back(v(6'b011001, 32'hCAFEF00D, 2'b01, 6'b111000));
    tbl.push_back(v(6'b000000, 0,            2'b01, 6'b000000));
    // reset, then tie -> m0, handoff -> m1, tie again -> m0
    tbl.push_back(v(6'b100000, 0,            2'b00, 6'b000000));
    tbl.push_back(v(6'b011110, 0,            2'b00, 6'b000000));
    tbl.push_back(v(6'b011111, 32'h11111111, 2'b01, 6'b111000));
    tbl.push_back(v(6'b000110, 0,            2'b01, 6'b000000));
    tbl.push_back(v(6'b000111, 32'h22222222, 2'b10, 6'b110100));
    tbl.push_back(v(6'b000000, 0,            2'b10, 6'b000000));
    tbl.push_back(v(6'b011110, 0,            2'b00, 6'b000000));
    tbl.push_back(v(6'b011111, 32'h33333333, 2'b01, 6'b111000));
    tbl.push_back(v(6'b000110, 0,            2'b01, 6'b000000));
    tbl.push_back(v(6'b000110, 0,            2'b10, 6'b110000));
    // m1 holds cyc over four acked writes while m0 waits
    tbl.push_back(v(6'b011111, 0,            2'b10, 6'b110100));
    tbl.push_back(v(6'b011111, 0,            2'b10, 6'b110100));
    tbl.push_back(v(6'b011100, 0,            2'b10, 6'b100000));
    tbl.push_back(v(6'b011111, 0,            2'b10, 6'b110100));
    tbl.push_back(v(6'b011111, 0,            2'b10, 6'b110100));
    tbl.push_back(v(6'b011000, 0,            2'b10, 6'b000000));
    tbl.push_back(v(6'b011000, 0,            2'b01, 6'b110000));
    tbl.push_back(v(6'b011001, 0,            2'b01, 6'b111000));
    tbl.push_back(v(6'b000000, 0,            2'b01, 6'b000000));
    tbl.push_back(v(6'b000000, 0,            2'b00, 6'b000000));
    // reset mid-transfer while m1 owns the bus, then tie goes to m0
    tbl.push_back(v(6'b000110, 0,            2'b00, 6'b000000));
    tbl.push_back(v(6'b000110, 0,            2'b10, 6'b110000));
    tbl.push_back(v(6'b100110, 0,            2'b10, 6'b110000));
    tbl.push_back(v(6'b011110, 0,            2'b00, 6'b000000));
    tbl.push_back(v(6'b011110, 0,            2'b01, 6'b110000));
    tbl.push_back(v(6'b000000, 0,            2'b01, 6'b000000));
    tbl.push_back(v(6'b000000, 0,            2'b00, 6'b000000));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    run_timeout(0, 1'b0);
    run_timeout(0, 1'b1);
    run_timeout(1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
